fifo_ctrl_v2: RTL and testbench
===============================

Name: fifo_ctrl_v2

Overview:
- Parametrised synchronous FIFO; successor to the basic buffer used between systolic-array stages and the input/weight loaders.
- Adds the following over the basic buffer:
  - full DEPTH occupancy (no sacrificed slot)
  - occupancy count
  - programmable almost-full/almost-empty thresholds
  - optional first-word-fall-through (FWFT) read mode
  - synchronous flush
  - sticky overflow/underflow error flags
- Single clock domain. Sits wherever a PE row/column or the DMA front-end needs elastic buffering with back-pressure.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- DATA_WIDTH, 8, signed data word width.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents and pointers.
- w_en  in  1  write request.
- in_data  in  DATA_WIDTH  signed write data.
- r_en  in  1  read request (FWFT=1: acknowledge/pop).
- out_data  out  DATA_WIDTH  signed read data.
- out_valid  out  1  out_data holds valid read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full and not accepted.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Clock is clk. Reset rstn is asynchronous, active-low; all flops clear immediately on rstn=0.
- Values while in reset: out_data=0, out_valid=0, count=0, empty=1, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0. Storage array is not reset.
- Pointers are $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
- Wrap-around: the index is the low bits, so the pointer wraps naturally after DEPTH entries.
- Accept conditions:
  - wr_ok = w_en & (!full | rd_ok)
  - rd_ok = r_en & !empty
- count updates each cycle: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- Full boundary: simultaneous w_en & r_en while full → both accepted, count stays DEPTH, no overflow.
- Empty boundary: simultaneous w_en & r_en while empty → write accepted, read ignored, underflow set, count becomes 1.
- Flags: full, empty, almost_* are decoded combinationally from the registered count, so they are valid in the cycle after the causing edge.
- FWFT=0 (standard mode):
  - On rd_ok, out_data <= mem[rd_ptr] and out_valid <= 1 for exactly one cycle.
  - Otherwise out_data holds its last value and out_valid <= 0.
  - Latency is 1 cycle from r_en to data.
- FWFT=1:
  - out_data = mem[rd_ptr] combinationally; out_valid = !empty.
  - r_en with out_valid pops the head. First word is visible the cycle after its write edge.
  - When empty, out_data is 0 (gated).
- Error flags:
  - overflow <= 1 when w_en & full & !rd_ok.
  - underflow <= 1 when r_en & empty.
  - Both are sticky until clr_err=1 or reset. If clr_err and a new error coincide, the new error wins (flag remains set).
- flush has priority over w_en/r_en. On flush: pointers=0, count=0, out_valid=0. out_data holds in FWFT=0 and reads 0 in FWFT=1. Error flags are unaffected.
- Reset asserted mid-transfer drops all contents; the first write after rstn release lands in entry 0.

Decomposition:
- Package fifo_pkg holds:
  - function ptr_w(DEPTH) = $clog2(DEPTH)+1
  - localparam checks (DEPTH power of two, AE_LEVEL < AF_LEVEL)
  - mode constants FIFO_STD=0, FIFO_FWFT=1
- Sub-module fifo_mem: DEPTH x DATA_WIDTH register file, one synchronous write port, one asynchronous read port.
- fifo_ctrl_v2 holds pointers, count, flags and the output stage.

Test Plan:
- DEPTH=8, FWFT=0: write 1..8 → full=1 and count=8 after the 8th edge. Then read 8 times → out_data 1..8, each one cycle after r_en, out_valid pulses, empty=1 at the end.
- Full, w_en=1 with in_data=9 and r_en=0 → overflow=1, count stays 8, data 9 is never read. Then clr_err → overflow=0.
- Full, w_en=1 (in_data=-5) and r_en=1 together → count stays 8, out_data=1. After draining, the last value read is -5.
- Empty, r_en=1 → underflow=1, out_valid=0. Then w_en and r_en together with in_data=3 → count=1, underflow stays set.
- FWFT=1: write 0x7F → next cycle out_valid=1 and out_data=127 with no r_en. Pulse r_en → empty=1, out_data=0.
- Thresholds and flush: fill 6 entries with AF_LEVEL=6 → almost_full=1. Flush → count=0, empty=1, almost_empty=1. Assert rstn=0 asynchronously mid-write → all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the fifo_ctrl_v2 family.
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter.
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Pointer width: index bits plus one wrap bit to tell full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when depth is a power of two and at least 2.
    function automatic bit is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // Legal configuration: power-of-two depth, thresholds in range, AE below AF.
    function automatic bit cfg_ok(input int depth, input int af_level, input int ae_level);
        return is_pow2(depth)
            && (af_level >= 1) && (af_level <= depth)
            && (ae_level >= 0) && (ae_level <= depth - 1)
            && (ae_level < af_level);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    localparam int AW        = ptr_w(DEPTH) - 1
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]                raddr,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    logic signed [DATA_WIDTH-1:0] mem_reg [DEPTH];

    // Write port: store the incoming word on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    // Read port is combinational so the controller can register or pass it through.
    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/fifo_ctrl_v2.sv
// Synchronous FIFO controller: pointers, occupancy, threshold flags,
// sticky error flags and a standard or first-word-fall-through output stage.
module fifo_ctrl_v2
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = FIFO_STD,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 1,
    localparam int PW        = ptr_w(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         w_en,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         r_en,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [PW-1:0]                count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_err
);

    localparam int AW = PW - 1;
    localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

    if (!cfg_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_cfg_check
        $error("fifo_ctrl_v2: illegal DEPTH / AF_LEVEL / AE_LEVEL combination");
    end

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          rd_ok, wr_ok, rd_go, wr_go;
    logic signed [DATA_WIDTH-1:0] mem_rdata;

    // Full/empty come from the registered pointers; the wrap bit separates them.
    assign empty        = (wr_ptr_reg == rd_ptr_reg);
    assign full         = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0])
                       && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign almost_full  = (count_reg >= AF_CNT);
    assign almost_empty = (count_reg <= AE_CNT);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A read frees a slot, so a write into a full FIFO is legal when paired with one.
    assign rd_ok = r_en & ~empty;
    assign wr_ok = w_en & (~full | rd_ok);
    // Flush overrides any transfer in the same cycle.
    assign rd_go = rd_ok & ~flush;
    assign wr_go = wr_ok & ~flush;

    fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_go),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Next-state for pointers, occupancy and the sticky error flags.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + PW'(wr_go);
        rd_ptr_next = rd_ptr_reg + PW'(rd_go);
        count_next  = count_reg;
        if (wr_go && !rd_go) begin
            count_next = count_reg + PW'(1);
        end else if (rd_go && !wr_go) begin
            count_next = count_reg - PW'(1);
        end
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
        // A fresh error in the same cycle as clr_err keeps the flag set.
        overflow_next  = (overflow_reg  & ~clr_err) | (w_en & full & ~rd_ok);
        underflow_next = (underflow_reg & ~clr_err) | (r_en & empty);
    end

    // Control state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word is presented directly; gated to zero when nothing is stored.
        assign out_valid = ~empty;
        assign out_data  = empty ? '0 : mem_rdata;
    end else begin : g_std
        logic signed [DATA_WIDTH-1:0] out_data_reg, out_data_next;
        logic                         out_valid_reg, out_valid_next;

        // Capture the head on an accepted read; valid pulses for one cycle.
        always_comb begin
            out_data_next  = out_data_reg;
            out_valid_next = 1'b0;
            if (rd_go) begin
                out_data_next  = mem_rdata;
                out_valid_next = 1'b1;
            end
        end

        // Registered read-data stage.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                out_data_reg  <= '0;
                out_valid_reg <= 1'b0;
            end else begin
                out_data_reg  <= out_data_next;
                out_valid_reg <= out_valid_next;
            end
        end

        assign out_data  = out_data_reg;
        assign out_valid = out_valid_reg;
    end

endmodule

// File: tb/tb_fifo_ctrl_v2.sv
// Directed, table-driven bench for fifo_ctrl_v2: one standard-mode and one
// FWFT instance, DEPTH=8, default thresholds (AF=6, AE=1).
module tb_fifo_ctrl_v2;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rstn;

    // Standard-mode instance signals
    logic s_flush, s_w, s_r, s_clr;
    logic signed [DW-1:0] s_din, s_dout;
    logic s_vld, s_full, s_empty, s_af, s_ae, s_ov, s_uf;
    logic [PW-1:0] s_cnt;

    // FWFT instance signals
    logic f_flush, f_w, f_r, f_clr;
    logic signed [DW-1:0] f_din, f_dout;
    logic f_vld, f_full, f_empty, f_af, f_ae, f_ov, f_uf;
    logic [PW-1:0] f_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_ctrl_v2 #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0)) u_std (
        .clk(clk), .rstn(rstn), .flush(s_flush), .w_en(s_w), .in_data(s_din),
        .r_en(s_r), .out_data(s_dout), .out_valid(s_vld), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ov), .underflow(s_uf), .clr_err(s_clr)
    );

    fifo_ctrl_v2 #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
        .clk(clk), .rstn(rstn), .flush(f_flush), .w_en(f_w), .in_data(f_din),
        .r_en(f_r), .out_data(f_dout), .out_valid(f_vld), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ov), .underflow(f_uf), .clr_err(f_clr)
    );

    typedef struct {
        bit flush, w, r, clr;
        int din;
        int cnt;
        bit vld;
        bit chk_d;
        int dout;
        bit ov, uf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit flush, bit w, bit r, bit clr, int din,
                                int cnt, bit vld, bit chk_d, int dout, bit ov, bit uf);
        vec_t v;
        v.flush = flush; v.w = w; v.r = r; v.clr = clr; v.din = din;
        v.cnt = cnt; v.vld = vld; v.chk_d = chk_d; v.dout = dout; v.ov = ov; v.uf = uf;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_idle();
        s_flush = 0; s_w = 0; s_r = 0; s_clr = 0; s_din = '0;
    endtask

    task automatic f_idle();
        f_flush = 0; f_w = 0; f_r = 0; f_clr = 0; f_din = '0;
    endtask

    // Occupancy-derived flags compared against the count the vector expects.
    task automatic chk_std_state(input string tag, input int cnt, input bit ov, input bit uf);
        chk({tag, ".count"}, int'(s_cnt), cnt);
        chk({tag, ".full"}, int'(s_full), int'(cnt == DEPTH));
        chk({tag, ".empty"}, int'(s_empty), int'(cnt == 0));
        chk({tag, ".almost_full"}, int'(s_af), int'(cnt >= DEPTH - 2));
        chk({tag, ".almost_empty"}, int'(s_ae), int'(cnt <= 1));
        chk({tag, ".overflow"}, int'(s_ov), int'(ov));
        chk({tag, ".underflow"}, int'(s_uf), int'(uf));
    endtask

    initial begin
        rstn = 1'b0;
        s_idle();
        f_idle();

        // Reset values while rstn is held low
        #3;
        chk_std_state("rst", 0, 0, 0);
        chk("rst.out_valid", int'(s_vld), 0);
        chk("rst.out_data", int'(s_dout), 0);
        chk("rst.f_out_valid", int'(f_vld), 0);
        chk("rst.f_out_data", int'(f_dout), 0);
        chk("rst.f_empty", int'(f_empty), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Standard-mode vector table
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, 0, 0, i, i, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 9, 8, 0, 0, 0, 1, 0));       // overflow on full
        vecs.push_back(mk(0, 0, 0, 1, 0, 8, 0, 0, 0, 0, 0));       // clr_err
        vecs.push_back(mk(0, 1, 1, 0, -5, 8, 1, 1, 1, 0, 0));      // write+read while full
        for (int i = 2; i <= 8; i++) vecs.push_back(mk(0, 0, 1, 0, 0, 9 - i, 1, 1, i, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, -5, 0, 0));      // -5 drained last, 9 never seen
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, -5, 0, 1));      // read while empty
        vecs.push_back(mk(0, 1, 1, 0, 3, 1, 0, 1, -5, 0, 1));      // w+r while empty
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));       // clear underflow
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 3, 0, 0));
        for (int i = 1; i <= 6; i++) vecs.push_back(mk(0, 1, 0, 0, 10 + i, i, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 99, 0, 0, 1, 3, 0, 0));      // flush beats w_en/r_en
        vecs.push_back(mk(0, 1, 0, 0, 42, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 42, 0, 0));

        foreach (vecs[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            s_flush = vecs[k].flush; s_w = vecs[k].w; s_r = vecs[k].r;
            s_clr = vecs[k].clr; s_din = DW'(vecs[k].din);
            tick();
            chk_std_state(tag, vecs[k].cnt, vecs[k].ov, vecs[k].uf);
            chk({tag, ".out_valid"}, int'(s_vld), int'(vecs[k].vld));
            if (vecs[k].chk_d) chk({tag, ".out_data"}, int'(s_dout), vecs[k].dout);
            $display("vec %0d: fl=%0d w=%0d r=%0d clr=%0d din=%0d -> count=%0d vld=%0d dout=%0d ov=%0d uf=%0d",
                     k, vecs[k].flush, vecs[k].w, vecs[k].r, vecs[k].clr, vecs[k].din,
                     s_cnt, s_vld, s_dout, s_ov, s_uf);
        end
        s_idle();

        // Asynchronous reset in the middle of a write burst
        s_r = 1; tick(); s_idle();
        chk("arst.pre_underflow", int'(s_uf), 1);
        s_w = 1; s_din = 50; tick();
        s_din = 51; tick();
        s_din = 52;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk_std_state("arst", 0, 0, 0);
        chk("arst.out_valid", int'(s_vld), 0);
        chk("arst.out_data", int'(s_dout), 0);
        $display("async reset: count=%0d empty=%0d uf=%0d dout=%0d", s_cnt, s_empty, s_uf, s_dout);
        s_idle();
        @(negedge clk);
        rstn = 1'b1;
        s_w = 1; s_din = 77; tick(); s_idle();
        chk("arst.count_after_write", int'(s_cnt), 1);
        s_r = 1; tick(); s_idle();
        chk("arst.read_data", int'(s_dout), 77);
        chk("arst.read_valid", int'(s_vld), 1);
        $display("post-reset read: dout=%0d vld=%0d", s_dout, s_vld);

        // FWFT instance
        f_w = 1; f_din = 8'sh7F; tick(); f_idle();
        chk("fwft.valid_after_write", int'(f_vld), 1);
        chk("fwft.data_after_write", int'(f_dout), 127);
        chk("fwft.count", int'(f_cnt), 1);
        tick();
        chk("fwft.data_held", int'(f_dout), 127);
        f_r = 1; tick(); f_idle();
        chk("fwft.empty_after_pop", int'(f_empty), 1);
        chk("fwft.data_gated", int'(f_dout), 0);
        chk("fwft.valid_after_pop", int'(f_vld), 0);
        $display("fwft pop: empty=%0d dout=%0d vld=%0d", f_empty, f_dout, f_vld);
        f_w = 1; f_din = 5; tick();
        f_din = 6; tick(); f_idle();
        chk("fwft.head_first", int'(f_dout), 5);
        f_r = 1; tick(); f_idle();
        chk("fwft.head_second", int'(f_dout), 6);
        chk("fwft.count_second", int'(f_cnt), 1);
        f_flush = 1; tick(); f_idle();
        chk("fwft.flush_empty", int'(f_empty), 1);
        chk("fwft.flush_data", int'(f_dout), 0);
        chk("fwft.flush_valid", int'(f_vld), 0);
        $display("fwft flush: empty=%0d dout=%0d vld=%0d", f_empty, f_dout, f_vld);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
